// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the fetch stage (master) and imem (slave).
// One request is outstanding at a time; imem_ack is a one-cycle data-valid pulse.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction fetch stage: PC, req/ack fetch FSM, one-entry skid buffer
// and the IF/ID output register, with decode-side stall and redirect (flush).
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  if_stage_if.master        imem,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       ins,
  output logic              ins_valid,
  output logic [31:0]       pc_out,
  output logic [31:0]       pc_plus4
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] pend_pc_q,   pend_pc_d;
  logic [31:0] ins_q,       ins_d;
  logic [31:0] pc_out_q,    pc_out_d;
  logic        ins_valid_q, ins_valid_d;
  logic [31:0] skid_q,      skid_d;
  logic [31:0] skid_pc_q,   skid_pc_d;

  logic [31:0] target_pc;
  logic [31:0] pc_next_seq;
  logic        slot_free;

  assign target_pc   = {redirect_pc[31:2], 2'b00};
  assign pc_next_seq = pc_q + 32'd4;
  assign slot_free   = !ins_valid_q || !stall;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    ins_d       = ins_q;
    pc_out_d    = pc_out_q;
    ins_valid_d = ins_valid_q;
    skid_d      = skid_q;
    skid_pc_d   = skid_pc_q;

    if (ins_valid_q && !stall) begin
      ins_valid_d = 1'b0;
    end

    if (redirect) begin
      // Flush: the output slot empties and leaving S_FULL drops the skid entry.
      ins_valid_d = 1'b0;
      case (state_q)
        S_WAIT: begin
          if (imem.imem_ack) begin
            pc_d    = target_pc;
            state_d = S_WAIT;
          end else begin
            pend_pc_d = target_pc;
            state_d   = S_DROP;
          end
        end
        S_DROP: begin
          pend_pc_d = target_pc;
          if (imem.imem_ack) begin
            pc_d    = target_pc;
            state_d = S_WAIT;
          end
        end
        default: begin
          pc_d    = target_pc;
          state_d = S_WAIT;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_ack) begin
            pc_d = pc_next_seq;
            if (slot_free) begin
              ins_d       = imem.imem_rdata;
              pc_out_d    = pc_q;
              ins_valid_d = 1'b1;
            end else begin
              skid_d    = imem.imem_rdata;
              skid_pc_d = pc_q;
              state_d   = S_FULL;
            end
          end
        end
        S_FULL: begin
          // In S_FULL the output register is always valid, so slot free == !stall.
          if (!stall) begin
            ins_d       = skid_q;
            pc_out_d    = skid_pc_q;
            ins_valid_d = 1'b1;
            state_d     = S_WAIT;
          end
        end
        S_DROP: begin
          if (imem.imem_ack) begin
            pc_d    = pend_pc_q;
            state_d = S_WAIT;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      pend_pc_q   <= RESET_PC;
      ins_q       <= 32'd0;
      pc_out_q    <= 32'd0;
      ins_valid_q <= 1'b0;
      // NOTE: the skid data is only meaningful in S_FULL, but it is reset anyway
      // so the stage comes out of reset with fully deterministic contents.
      skid_q      <= 32'd0;
      skid_pc_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      ins_q       <= ins_d;
      pc_out_q    <= pc_out_d;
      ins_valid_q <= ins_valid_d;
      skid_q      <= skid_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  // pc_q is the in-flight address in both S_WAIT and S_DROP, so it never
  // moves while a request is outstanding.
  assign imem.imem_req  = (state_q == S_WAIT) || (state_q == S_DROP);
  assign imem.imem_addr = pc_q;

  assign ins       = ins_q;
  assign ins_valid = ins_valid_q;
  assign pc_out    = pc_out_q;
  assign pc_plus4  = pc_out_q + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then randomized stall,
// latency and redirect, checked against an in-order instruction-stream model.
module tb_if_stage;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] ins, pc_out, pc_plus4;
  logic        ins_valid;
  logic [31:0] w_ins, w_pc_out, w_pc_plus4;
  logic        w_ins_valid;

  if_stage_if imem_if ();
  if_stage_if wrap_if ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_if),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins         (ins),
    .ins_valid   (ins_valid),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4)
  );

  if_stage #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (wrap_if),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'd0),
    .ins         (w_ins),
    .ins_valid   (w_ins_valid),
    .pc_out      (w_pc_out),
    .pc_plus4    (w_pc_plus4)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_cons   = 0;
  int          n_wcons  = 0;
  int          mem_cnt  = 0;
  int          lat_sel  = 0;
  int          idle_cnt = 0;
  logic [31:0] exp_pc   = 32'd0;
  logic [31:0] exp_wpc  = WRAP_PC;
  logic [31:0] prev_addr = 32'd0;
  logic        pend_prev = 1'b0;
  logic        rd_prev   = 1'b0;
  logic        mem_busy  = 1'b0;
  logic        force_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hA5C3_0F1E;
  endfunction

  // One clock cycle: called at a negedge, drives this cycle's inputs, checks the
  // outputs against the stream model, then advances to the next negedge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    if (!rst_n) begin
      imem_if.imem_ack   = 1'b0;
      imem_if.imem_rdata = 32'hDEAD_BEEF;
      wrap_if.imem_ack   = 1'b0;
      wrap_if.imem_rdata = 32'hDEAD_BEEF;
      exp_pc    = 32'd0;
      exp_wpc   = WRAP_PC;
      mem_busy  = 1'b0;
      pend_prev = 1'b0;
      rd_prev   = 1'b0;
      idle_cnt  = 0;
    end else begin
      if (pend_prev) begin
        check("req_hold", imem_if.imem_req, 1'b1);
        check("addr_hold", imem_if.imem_addr, prev_addr);
      end
      if (rd_prev) check("flush_valid", ins_valid, 1'b0);

      if (force_ack) begin
        imem_if.imem_ack = 1'b1;
      end else if (imem_if.imem_req) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_cnt  = (lat_sel >= 0) ? lat_sel : int'($urandom_range(0, 3));
        end
        if (mem_cnt == 0) begin
          imem_if.imem_ack = 1'b1;
          mem_busy = 1'b0;
        end else begin
          imem_if.imem_ack = 1'b0;
          mem_cnt--;
        end
      end else begin
        imem_if.imem_ack = 1'b0;
        mem_busy = 1'b0;
      end
      imem_if.imem_rdata = imem_if.imem_ack ? mem_word(imem_if.imem_addr) : 32'hDEAD_BEEF;

      if (ins_valid && !st) begin
        check("pc_out", pc_out, exp_pc);
        check("ins", ins, mem_word(exp_pc));
        check("pc_plus4", pc_plus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_cons++;
        idle_cnt = 0;
      end else begin
        idle_cnt++;
      end
      check("liveness", idle_cnt < 40, 1'b1);
      if (rd) exp_pc = rpc & ~32'd3;

      pend_prev = imem_if.imem_req && !imem_if.imem_ack;
      prev_addr = imem_if.imem_addr;
      rd_prev   = rd;

      wrap_if.imem_ack   = wrap_if.imem_req;
      wrap_if.imem_rdata = wrap_if.imem_req ? mem_word(wrap_if.imem_addr) : 32'hDEAD_BEEF;
      if (w_ins_valid) begin
        check("wrap_pc_out", w_pc_out, exp_wpc);
        check("wrap_ins", w_ins, mem_word(exp_wpc));
        check("wrap_pc_plus4", w_pc_plus4, exp_wpc + 32'd4);
        exp_wpc = exp_wpc + 32'd4;
        n_wcons++;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ins"}, ins, 32'd0);
    check({tag, "_pc_out"}, pc_out, 32'd0);
    check({tag, "_valid"}, ins_valid, 1'b0);
    check({tag, "_req"}, imem_if.imem_req, 1'b0);
    check({tag, "_addr"}, imem_if.imem_addr, 32'd0);
  endtask

  initial begin
    int      guard;
    logic [31:0] rpc;

    imem_if.imem_ack = 1'b0;  imem_if.imem_rdata = 32'd0;
    wrap_if.imem_ack = 1'b0;  wrap_if.imem_rdata = 32'd0;

    // Reset state
    @(negedge clk);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    check_reset_outputs("rst");
    check("rst_wrap_req", wrap_if.imem_req, 1'b0);
    check("rst_wrap_addr", wrap_if.imem_addr, WRAP_PC);
    rst_n = 1'b1;

    // Redirect to 0x102 while the 2-wait fetch of 0x10 is in flight
    lat_sel = 2;
    guard = 0;
    while (!(imem_if.imem_req && imem_if.imem_addr == 32'h10 && !mem_busy) && guard < 60) begin
      step(1'b0, 1'b0, 32'd0);
      guard++;
    end
    check("reach_0x10", guard < 60, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0102);
    guard = 0;
    while (imem_if.imem_addr == 32'h10 && guard < 10) begin
      step(1'b0, 1'b0, 32'd0);
      guard++;
    end
    check("drop_next_addr", imem_if.imem_addr, 32'h100);
    check("drop_next_req", imem_if.imem_req, 1'b1);

    // Zero-wait throughput: one instruction every cycle
    lat_sel = 0;
    repeat (4) step(1'b0, 1'b0, 32'd0);
    repeat (8) begin
      check("throughput_valid", ins_valid, 1'b1);
      step(1'b0, 1'b0, 32'd0);
    end

    // Stall four cycles: next word goes to the skid, fetching stops
    step(1'b1, 1'b0, 32'd0);
    repeat (3) begin
      check("full_req", imem_if.imem_req, 1'b0);
      step(1'b1, 1'b0, 32'd0);
    end
    repeat (3) step(1'b0, 1'b0, 32'd0);

    // Redirect in the same cycle as an ack
    guard = 0;
    while (!imem_if.imem_req && guard < 10) begin
      step(1'b0, 1'b0, 32'd0);
      guard++;
    end
    step(1'b0, 1'b1, 32'h0000_0200);
    check("ack_redir_addr", imem_if.imem_addr, 32'h200);
    check("ack_redir_req", imem_if.imem_req, 1'b1);

    // Redirect while stalled with the skid buffer full
    repeat (2) step(1'b0, 1'b0, 32'd0);
    repeat (3) step(1'b1, 1'b0, 32'd0);
    check("skid_full_req", imem_if.imem_req, 1'b0);
    check("skid_full_valid", ins_valid, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0303);
    check("skid_redir_addr", imem_if.imem_addr, 32'h300);
    check("skid_redir_req", imem_if.imem_req, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'd0);

    // Reset during S_WAIT, then an ack while in S_IDLE is ignored
    lat_sel = 3;
    guard = 0;
    while (!(imem_if.imem_req && mem_busy) && guard < 10) begin
      step(1'b0, 1'b0, 32'd0);
      guard++;
    end
    rst_n = 1'b0;
    step(1'b0, 1'b0, 32'd0);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    force_ack = 1'b1;
    step(1'b0, 1'b0, 32'd0);
    force_ack = 1'b0;
    check("idle_ack_valid", ins_valid, 1'b0);
    check("idle_ack_req", imem_if.imem_req, 1'b1);
    check("idle_ack_addr", imem_if.imem_addr, 32'd0);

    // Randomized stall, latency and redirect
    lat_sel = -1;
    repeat (3000) begin
      logic st, rd;
      st = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 99) < 5);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc = 32'($urandom_range(0, 255));
      endcase
      step(st, rd, rpc);
    end

    check("consumed_enough", n_cons > 300, 1'b1);
    check("wrap_consumed", n_wcons > 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction fetch stage for the MIPS pipeline, directly upstream of the instruction field decoder.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents each fetched 32-bit instruction word, with its PC, in an IF/ID output register.
- Handles decode-side stall, branch/jump redirect (flush), and variable memory latency.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  32  fetch byte address (= current PC); stable while imem_req high
imem_ack  input  1  one-cycle pulse: imem_rdata valid for request in flight
imem_rdata  input  32  instruction word returned
stall  input  1  downstream cannot consume ins this cycle
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
ins  output  32  IF/ID instruction word to decoder
ins_valid  output  1  ins/pc_out hold a valid instruction
pc_out  output  32  PC of ins
pc_plus4  output  32  pc_out + 4, combinational, wraps mod 2^32

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, state=S_IDLE, ins=0, pc_out=0, ins_valid=0, skid buffer empty; imem_req=0, imem_addr=RESET_PC.
- Output register is consumed on any cycle with ins_valid=1 and stall=0. "slot free" = !ins_valid || !stall.
- States:
  - S_IDLE: imem_req=0. Next cycle -> S_WAIT. Entered only from reset.
  - S_WAIT: imem_req=1, imem_addr=pc.
    - No ack: stay.
    - Ack and slot free: ins<=imem_rdata, pc_out<=pc, ins_valid<=1, pc<=pc+4; stay in S_WAIT. Back-to-back requests are allowed; the new address appears the cycle after the ack.
    - Ack and slot not free: skid<=imem_rdata, skid_pc<=pc, pc<=pc+4 -> S_FULL.
  - S_FULL: imem_req=0. When stall=0: ins<=skid, pc_out<=skid_pc, ins_valid<=1 -> S_WAIT. While stall=1: hold all state.
  - S_DROP: imem_req=1, imem_addr=pc (the address in flight before redirect). On ack: discard data, pc<=redirect target latched earlier -> S_WAIT.
- ins_valid clears when consumed (stall=0) and no new instruction loads in the same cycle.
- Redirect (priority: reset > redirect > all else):
  - Sets ins_valid<=0 and empties the skid buffer, regardless of stall.
  - In S_WAIT without same-cycle ack: latch redirect_pc into pending register -> S_DROP. The in-flight request completes and its data is discarded.
  - In S_WAIT with same-cycle ack: discard data, pc<=redirect_pc -> S_WAIT.
  - In S_IDLE or S_FULL: pc<=redirect_pc -> S_WAIT.
  - In S_DROP: pending target overwritten by the newest redirect_pc; if ack arrives the same cycle, pc<=new redirect_pc -> S_WAIT.
- No more than one request is outstanding. imem_addr never changes while imem_req=1 and ack has not yet occurred.
- PC arithmetic is 32-bit unsigned with wrap: 32'hFFFF_FFFC+4 = 0.
- Reset mid-transaction: all state returns to reset values. Any later ack while in S_IDLE is ignored.
- Throughput: 1 instruction/cycle when memory acks every cycle and stall=0.

Test Plan:
- Reset then zero-wait memory (ack every cycle after req, rdata=addr|32'hA000_0000): ins sequence A000_0000, A000_0004, A000_0008; pc_out 0,4,8; ins_valid continuous from 3rd cycle after reset release; pc_plus4 = pc_out+4.
- 3-cycle memory latency: imem_addr held at 0x4 for 3 cycles with imem_req=1. ins_valid pulses one cycle per fetch with stall=0.
- Stall for 4 cycles while ack arrives for 0x8:
  - ins/pc_out frozen at 0x4 word; fetch of 0x8 goes to skid; imem_req=0 in S_FULL.
  - On stall release, 0x8 word appears next cycle; no word lost or duplicated.
- Redirect to 0x0000_0102 with request to 0x10 in flight (ack 2 cycles later):
  - ins_valid=0 the next cycle; 0x10 data discarded.
  - Next imem_addr=0x0000_0100; first valid pc_out=0x100.
- Redirect in same cycle as ack, and redirect while stall=1 with skid full: both flush, next fetch at redirect target; no stale instruction appears at ins_valid.
- Wrap/reset: RESET_PC=32'hFFFF_FFFC gives fetches FFFF_FFFC then 0000_0000. rst_n=0 during S_WAIT gives all outputs at reset values the next cycle, and an ack while in S_IDLE is ignored.
